vrf_read_streamer: RTL and testbench

VRF_READ_STREAMER -- requirements
Module: vrf_read_streamer

---
 rtl/vrf_stream_if.sv | 24 ++
 rtl/vrf_read_streamer.sv | 110 +++++++++++
 tb/tb_vrf_read_streamer.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/vrf_stream_if.sv
// Word stream from the vector register file reader to its consumer.
// The master drives data/valid/last; the slave drives ready.
interface vrf_stream_if #(
    parameter int WORD = 32
);
    logic [WORD-1:0] out_data;
    logic            out_valid;
    logic            out_ready;
    logic            out_last;

    modport master (
        output out_data,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/vrf_read_streamer.sv
// Streams a run of vector registers out of the register file as words,
// least-significant word first, with valid/ready flow control.
module vrf_read_streamer #(
    parameter int DEPTH = 16,
    parameter int BITS  = 128,
    parameter int WORD  = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [$clog2(DEPTH)-1:0]   first_addr,
    input  logic [$clog2(DEPTH):0]     count,
    output logic [$clog2(DEPTH)-1:0]   rf_address,
    input  logic [BITS-1:0]            rf_read,
    output logic                       busy,
    output logic                       done,
    vrf_stream_if.master               stream
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int NW = BITS / WORD;
    localparam int IW = (NW > 1) ? $clog2(NW) : 1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] FETCH  = 2'd1;
    localparam logic [1:0] SEND   = 2'd2;
    localparam logic [1:0] FINISH = 2'd3;

    localparam logic [IW-1:0] LAST_IDX  = IW'(NW - 1);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [CW-1:0] ONE_LEFT  = CW'(1);

    logic [1:0]      state;
    logic [AW-1:0]   cur_addr;
    logic [CW-1:0]   remaining;
    logic [BITS-1:0] shreg;
    logic [IW-1:0]   word_idx;

    logic [AW-1:0]   next_addr;
    logic            last_word;
    logic            xfer;

    // DEPTH need not be a power of two, so wrap explicitly.
    assign next_addr = (cur_addr == LAST_ADDR) ? '0
                     : cur_addr + AW'(1);

    assign last_word = (word_idx == LAST_IDX);
    assign xfer      = (state == SEND) && stream.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cur_addr  <= '0;
            remaining <= '0;
            shreg     <= '0;
            word_idx  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        if (count != '0) begin
                            cur_addr  <= first_addr;
                            remaining <= count;
                            state     <= FETCH;
                        end else begin
                            state <= FINISH;
                        end
                    end
                end
                FETCH: begin
                    shreg    <= rf_read;
                    word_idx <= '0;
                    state    <= SEND;
                end
                SEND: begin
                    if (xfer) begin
                        shreg <= shreg >> WORD;
                        if (last_word) begin
                            word_idx  <= '0;
                            remaining <= remaining - CW'(1);
                            if (remaining != ONE_LEFT) begin
                                cur_addr <= next_addr;
                                state    <= FETCH;
                            end else begin
                                state <= FINISH;
                            end
                        end else begin
                            word_idx <= word_idx + IW'(1);
                        end
                    end
                end
                FINISH: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Outputs are decoded from registered state, so they hold under stall.
    assign rf_address       = cur_addr;
    assign stream.out_valid = (state == SEND);
    assign stream.out_data  = shreg[WORD-1:0];
    assign stream.out_last  = (state == SEND) && last_word
                            && (remaining == ONE_LEFT);
    assign busy             = (state != IDLE);
    assign done             = (state == FINISH);
endmodule

// File: tb/tb_vrf_read_streamer.sv
// Directed bench for vrf_read_streamer with a behavioural register file
// and a word scoreboard.
module tb_vrf_read_streamer;
    logic         clk;
    logic         rst;
    logic         start;
    logic [3:0]   first_addr;
    logic [4:0]   count;
    logic [3:0]   rf_address;
    logic [127:0] rf_read;
    logic         busy;
    logic         done;

    logic [127:0] rf [16];
    logic [31:0]  exp_w [$];
    logic [3:0]   fetch_addr [16];

    int n_chk;
    int n_err;

    vrf_stream_if #(.WORD(32)) s ();

    vrf_read_streamer #(
        .DEPTH(16),
        .BITS (128),
        .WORD (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .first_addr(first_addr),
        .count     (count),
        .rf_address(rf_address),
        .rf_read   (rf_read),
        .busy      (busy),
        .done      (done),
        .stream    (s)
    );

    assign rf_read = rf[rf_address];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag,
                         input logic [127:0] got,
                         input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_reg(input int a);
        logic [127:0] v;
        v = rf[a];
        for (int k = 0; k < 4; k++) begin
            exp_w.push_back(v[32*k +: 32]);
        end
    endtask

    // Called at the first cycle after the start edge (FETCH expected).
    task automatic run(input bit bp,
                       output int xf,
                       output int first_v,
                       output int done_c,
                       output int fetches);
        logic [31:0] held_d;
        logic        held_l;
        bit          holding;
        int          nw;
        nw      = exp_w.size();
        holding = 0;
        held_d  = '0;
        held_l  = 1'b0;
        xf      = 0;
        first_v = -1;
        done_c  = -1;
        fetches = 0;
        for (int c = 0; c < 300; c++) begin
            s.out_ready = bp ? ((c % 3) == 0) : 1'b1;
            if (holding) begin
                check("hold_valid", 128'(s.out_valid), 128'd1);
                check("hold_data", 128'(s.out_data), 128'(held_d));
                check("hold_last", 128'(s.out_last), 128'(held_l));
                holding = 0;
            end
            if (s.out_valid) begin
                if (first_v < 0) first_v = c;
                if (s.out_ready) begin
                    check("word_index_in_range", 128'(xf < nw), 128'd1);
                    if (xf < nw) begin
                        check($sformatf("word%0d", xf),
                              128'(s.out_data), 128'(exp_w[xf]));
                    end
                    check($sformatf("last%0d", xf),
                          128'(s.out_last), 128'(xf == nw - 1));
                    xf++;
                end else begin
                    holding = 1;
                    held_d  = s.out_data;
                    held_l  = s.out_last;
                end
            end else if (busy && !done) begin
                if (fetches < 16) fetch_addr[fetches] = rf_address;
                fetches++;
            end
            if (done) begin
                done_c = c;
                break;
            end
            tick();
        end
        check("done_seen", 128'(done_c >= 0), 128'd1);
        s.out_ready = 1'b1;
    endtask

    int xf, fv, dc, nf;

    initial begin
        n_chk = 0;
        n_err = 0;
        for (int i = 0; i < 16; i++) begin
            rf[i] = {4{8'(i), 24'h5A5A00}};
        end
        rf[0]  = '0;
        rf[1]  = 128'h11111111_22222222_33333333_44444444;
        rf[5]  = 128'h00112233_44556677_8899AABB_CCDDEEFF;
        rf[15] = 128'hF0F1F2F3_E0E1E2E3_D0D1D2D3_C0C1C2C3;

        rst         = 1'b1;
        start       = 1'b0;
        first_addr  = '0;
        count       = '0;
        s.out_ready = 1'b1;
        tick();
        tick();
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_valid", 128'(s.out_valid), 128'd0);
        check("rst_last", 128'(s.out_last), 128'd0);
        check("rst_done", 128'(done), 128'd0);
        check("rst_data", 128'(s.out_data), 128'd0);
        check("rst_addr", 128'(rf_address), 128'd0);
        rst = 1'b0;
        tick();

        // Single register, ready high throughout.
        exp_w = {32'hCCDDEEFF, 32'h8899AABB, 32'h44556677, 32'h00112233};
        first_addr = 4'd5;
        count      = 5'd1;
        start      = 1'b1;
        tick();
        start = 1'b0;
        check("single_fetch_addr", 128'(rf_address), 128'd5);
        check("single_fetch_busy", 128'(busy), 128'd1);
        run(1'b0, xf, fv, dc, nf);
        check("single_xfers", 128'(xf), 128'd4);
        check("single_first_valid", 128'(fv), 128'd1);
        check("single_done_cycle", 128'(dc), 128'd5);
        check("single_done_busy", 128'(busy), 128'd1);
        tick();
        check("single_idle_busy", 128'(busy), 128'd0);
        check("single_idle_done", 128'(done), 128'd0);

        // Address wrap 15 -> 0 -> 1, with start held and changed while busy.
        exp_w.delete();
        push_reg(15);
        for (int k = 0; k < 4; k++) exp_w.push_back(32'h0);
        push_reg(1);
        first_addr = 4'd15;
        count      = 5'd3;
        start      = 1'b1;
        tick();
        first_addr = 4'd7;
        count      = 5'd9;
        run(1'b0, xf, fv, dc, nf);
        start = 1'b0;
        check("wrap_xfers", 128'(xf), 128'd12);
        check("wrap_fetches", 128'(nf), 128'd3);
        check("wrap_addr0", 128'(fetch_addr[0]), 128'd15);
        check("wrap_addr1", 128'(fetch_addr[1]), 128'd0);
        check("wrap_addr2", 128'(fetch_addr[2]), 128'd1);
        check("wrap_done_cycle", 128'(dc), 128'd15);
        tick();
        check("wrap_idle", 128'(busy), 128'd0);

        // Backpressure with ready pattern 1,0,0 repeating.
        exp_w.delete();
        push_reg(1);
        push_reg(2);
        first_addr = 4'd1;
        count      = 5'd2;
        start      = 1'b1;
        tick();
        start = 1'b0;
        run(1'b1, xf, fv, dc, nf);
        check("bp_xfers", 128'(xf), 128'd8);
        check("bp_fetches", 128'(nf), 128'd2);
        tick();

        // count = 0: straight to FINISH, no words.
        first_addr = 4'd3;
        count      = 5'd0;
        start      = 1'b1;
        tick();
        start = 1'b0;
        check("zero_busy", 128'(busy), 128'd1);
        check("zero_done", 128'(done), 128'd1);
        check("zero_valid", 128'(s.out_valid), 128'd0);
        tick();
        check("zero_idle_busy", 128'(busy), 128'd0);
        check("zero_idle_done", 128'(done), 128'd0);
        check("zero_idle_valid", 128'(s.out_valid), 128'd0);

        // Reset after two words of a four-register transfer.
        first_addr = 4'd2;
        count      = 5'd4;
        start      = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("abort_w0", 128'(s.out_data), 128'(rf[2][31:0]));
        tick();
        check("abort_w1", 128'(s.out_data), 128'(rf[2][63:32]));
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", 128'(busy), 128'd0);
        check("abort_valid", 128'(s.out_valid), 128'd0);
        check("abort_done", 128'(done), 128'd0);
        check("abort_data", 128'(s.out_data), 128'd0);
        tick();
        check("abort_no_done", 128'(done), 128'd0);

        exp_w = {32'hCCDDEEFF, 32'h8899AABB, 32'h44556677, 32'h00112233};
        first_addr = 4'd5;
        count      = 5'd1;
        start      = 1'b1;
        tick();
        start = 1'b0;
        run(1'b0, xf, fv, dc, nf);
        check("restart_xfers", 128'(xf), 128'd4);
        check("restart_done_cycle", 128'(dc), 128'd5);
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
